cuenta_banco: RTL and testbench

- Account-balance responder on the far side of the ATM transaction block's balance interface.
- On card insertion, looks up the selected account and presents its balance on balance_inicial.
- Accepts the updated balance on each balance_stb pulse and commits it to internal account storage.
- Tracks session state, counts committed transactions per session and flags protocol errors and invalid accounts.

---
 rtl/cajero_pkg.sv | 13 +
 rtl/cuenta_banco_mem.sv | 46 ++++
 rtl/cuenta_banco.sv | 138 +++++++++++++
 tb/tb_cuenta_banco.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cajero_pkg.sv
// Shared types and widths for the account-balance responder and its storage.
package cajero_pkg;

    localparam int unsigned BAL_W_DEF = 64;
    localparam int unsigned TRANS_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SESION  = 2'd1,
        ST_RECHAZO = 2'd2
    } estado_t;

endpackage

// File: rtl/cuenta_banco_mem.sv
// Account register file: synchronous write, combinational read, reset to a common balance.
module cuenta_mem
    import cajero_pkg::*;
#(
    parameter int unsigned          NUM_CUENTAS = 4,
    parameter int unsigned          IDX_W       = 2,
    parameter int unsigned          BAL_W       = BAL_W_DEF,
    parameter logic [BAL_W-1:0]     SALDO_RESET = BAL_W'(1000)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [BAL_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [BAL_W-1:0] rdata
);

    localparam logic [IDX_W:0] NUM_C = (IDX_W+1)'(NUM_CUENTAS);

    logic [BAL_W-1:0] mem_q [NUM_CUENTAS];
    logic [BAL_W-1:0] mem_d [NUM_CUENTAS];

    // Out-of-range addresses read as zero and never write.
    always_comb begin
        mem_d = mem_q;
        if (we && ({1'b0, waddr} < NUM_C)) begin
            mem_d[waddr] = wdata;
        end
        rdata = '0;
        if ({1'b0, raddr} < NUM_C) begin
            rdata = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_CUENTAS; i++) begin
                mem_q[i] <= SALDO_RESET;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/cuenta_banco.sv
// Account-balance responder: opens one account per card session and commits balance updates.
module cuenta_banco
    import cajero_pkg::*;
#(
    parameter int unsigned          NUM_CUENTAS = 4,
    parameter int unsigned          IDX_W       = 2,
    parameter int unsigned          BAL_W       = BAL_W_DEF,
    parameter logic [BAL_W-1:0]     SALDO_RESET = BAL_W'(1000)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tarjeta_recibida,
    input  logic [IDX_W-1:0]   cuenta_id,
    output logic [BAL_W-1:0]   balance_inicial,
    output logic               balance_valido,
    input  logic [BAL_W-1:0]   balance_actualizado,
    input  logic               balance_stb,
    output logic               escritura_ok,
    output logic [TRANS_W-1:0] transacciones,
    output logic               cuenta_invalida,
    output logic               error_stb
);

    localparam logic [IDX_W:0] NUM_C = (IDX_W+1)'(NUM_CUENTAS);

    estado_t            state_q, state_d;
    logic [IDX_W-1:0]   id_lat_q, id_lat_d;
    logic [BAL_W-1:0]   bal_q, bal_d;
    logic               valido_q, valido_d;
    logic               ok_q, ok_d;
    logic [TRANS_W-1:0] trans_q, trans_d;
    logic               inval_q, inval_d;
    logic               err_q, err_d;

    logic               mem_we;
    logic [BAL_W-1:0]   mem_rdata;

    cuenta_mem #(
        .NUM_CUENTAS (NUM_CUENTAS),
        .IDX_W       (IDX_W),
        .BAL_W       (BAL_W),
        .SALDO_RESET (SALDO_RESET)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (id_lat_q),
        .wdata (balance_actualizado),
        .raddr (cuenta_id),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        id_lat_d = id_lat_q;
        bal_d    = bal_q;
        valido_d = valido_q;
        ok_d     = 1'b0;
        trans_d  = trans_q;
        inval_d  = inval_q;
        err_d    = 1'b0;
        mem_we   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                err_d = balance_stb;
                if (tarjeta_recibida) begin
                    if ({1'b0, cuenta_id} < NUM_C) begin
                        id_lat_d = cuenta_id;
                        bal_d    = mem_rdata;
                        valido_d = 1'b1;
                        trans_d  = '0;
                        state_d  = ST_SESION;
                    end else begin
                        inval_d  = 1'b1;
                        state_d  = ST_RECHAZO;
                    end
                end
            end
            ST_SESION: begin
                if (balance_stb) begin
                    mem_we = 1'b1;
                    bal_d  = balance_actualizado;
                    ok_d   = 1'b1;
                    if (trans_q != '1) begin
                        trans_d = trans_q + 1'b1;
                    end
                end
                // A write on the card-removal cycle still commits; only the visible balance clears.
                if (!tarjeta_recibida) begin
                    bal_d    = '0;
                    valido_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RECHAZO: begin
                err_d = balance_stb;
                if (!tarjeta_recibida) begin
                    inval_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            id_lat_q <= '0;
            bal_q    <= '0;
            valido_q <= 1'b0;
            ok_q     <= 1'b0;
            trans_q  <= '0;
            inval_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_lat_q <= id_lat_d;
            bal_q    <= bal_d;
            valido_q <= valido_d;
            ok_q     <= ok_d;
            trans_q  <= trans_d;
            inval_q  <= inval_d;
            err_q    <= err_d;
        end
    end

    assign balance_inicial = bal_q;
    assign balance_valido  = valido_q;
    assign escritura_ok    = ok_q;
    assign transacciones   = trans_q;
    assign cuenta_invalida = inval_q;
    assign error_stb       = err_q;

endmodule

// File: tb/tb_cuenta_banco.sv
// Directed bench for cuenta_banco: 4-account and 3-account instances share stimulus, checked against an account-level model.
module tb_cuenta_banco;

    logic        clk = 1'b0;
    logic        reset;
    logic        tarjeta_recibida;
    logic [1:0]  cuenta_id;
    logic [63:0] balance_actualizado;
    logic        balance_stb;

    logic [63:0] bal4, bal3;
    logic        val4, val3, ok4, ok3, inv4, inv3, err4, err3;
    logic [7:0]  tr4, tr3;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    cuenta_banco #(
        .NUM_CUENTAS (4),
        .IDX_W       (2),
        .BAL_W       (64),
        .SALDO_RESET (64'd1000)
    ) dut4 (
        .clk                 (clk),
        .reset               (reset),
        .tarjeta_recibida    (tarjeta_recibida),
        .cuenta_id           (cuenta_id),
        .balance_inicial     (bal4),
        .balance_valido      (val4),
        .balance_actualizado (balance_actualizado),
        .balance_stb         (balance_stb),
        .escritura_ok        (ok4),
        .transacciones       (tr4),
        .cuenta_invalida     (inv4),
        .error_stb           (err4)
    );

    cuenta_banco #(
        .NUM_CUENTAS (3),
        .IDX_W       (2),
        .BAL_W       (64),
        .SALDO_RESET (64'd1000)
    ) dut3 (
        .clk                 (clk),
        .reset               (reset),
        .tarjeta_recibida    (tarjeta_recibida),
        .cuenta_id           (cuenta_id),
        .balance_inicial     (bal3),
        .balance_valido      (val3),
        .balance_actualizado (balance_actualizado),
        .balance_stb         (balance_stb),
        .escritura_ok        (ok3),
        .transacciones       (tr3),
        .cuenta_invalida     (inv3),
        .error_stb           (err3)
    );

    // Account-level model, index 0 = 4-account instance, index 1 = 3-account instance.
    logic [63:0] m_saldo [2][4];
    bit          m_abierta [2];
    bit          m_rechazada [2];
    int          m_cuenta [2];
    logic [63:0] e_bal [2];
    bit          e_val [2], e_ok [2], e_inv [2], e_err [2];
    int          e_tr [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int n;
            n = (k == 0) ? 4 : 3;
            if (!reset) begin
                for (int a = 0; a < 4; a++) m_saldo[k][a] = 64'd1000;
                m_abierta[k] = 0; m_rechazada[k] = 0;
                e_bal[k] = 0; e_val[k] = 0; e_ok[k] = 0; e_inv[k] = 0; e_err[k] = 0; e_tr[k] = 0;
            end else begin
                e_ok[k]  = 0;
                e_err[k] = 0;
                if (m_abierta[k]) begin
                    if (balance_stb) begin
                        m_saldo[k][m_cuenta[k]] = balance_actualizado;
                        e_bal[k] = balance_actualizado;
                        e_ok[k]  = 1;
                        e_tr[k]  = (e_tr[k] < 255) ? e_tr[k] + 1 : 255;
                    end
                    if (!tarjeta_recibida) begin
                        m_abierta[k] = 0;
                        e_val[k] = 0;
                        e_bal[k] = 0;
                    end
                end else if (m_rechazada[k]) begin
                    e_err[k] = balance_stb;
                    if (!tarjeta_recibida) begin
                        m_rechazada[k] = 0;
                        e_inv[k] = 0;
                    end
                end else begin
                    e_err[k] = balance_stb;
                    if (tarjeta_recibida) begin
                        if (int'(cuenta_id) < n) begin
                            m_abierta[k] = 1;
                            m_cuenta[k]  = int'(cuenta_id);
                            e_bal[k] = m_saldo[k][cuenta_id];
                            e_val[k] = 1;
                            e_tr[k]  = 0;
                        end else begin
                            m_rechazada[k] = 1;
                            e_inv[k] = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("bal4", bal4, e_bal[0]);
        chk("val4", 64'(val4), 64'(e_val[0]));
        chk("ok4",  64'(ok4),  64'(e_ok[0]));
        chk("tr4",  64'(tr4),  64'(e_tr[0]));
        chk("inv4", 64'(inv4), 64'(e_inv[0]));
        chk("err4", 64'(err4), 64'(e_err[0]));
        chk("bal3", bal3, e_bal[1]);
        chk("val3", 64'(val3), 64'(e_val[1]));
        chk("ok3",  64'(ok3),  64'(e_ok[1]));
        chk("tr3",  64'(tr3),  64'(e_tr[1]));
        chk("inv3", 64'(inv3), 64'(e_inv[1]));
        chk("err3", 64'(err3), 64'(e_err[1]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b0; tarjeta_recibida = 1'b0; cuenta_id = 2'd0;
        balance_actualizado = 64'd0; balance_stb = 1'b0;

        tick(); tick();
        chk("lit_reset_bal", bal4, 64'd0);
        chk("lit_reset_val", 64'(val4), 64'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            cuenta_id = 2'(i); tarjeta_recibida = 1'b1;
            tick();
            chk("lit_open_val", 64'(val4), 64'd1);
            chk("lit_open_bal", bal4, 64'd1000);
            tarjeta_recibida = 1'b0;
            tick();
        end

        cuenta_id = 2'd2; tarjeta_recibida = 1'b1; tick();
        balance_actualizado = 64'd750; balance_stb = 1'b1; tick();
        balance_stb = 1'b0;
        chk("lit_w750_ok", 64'(ok4), 64'd1);
        chk("lit_w750_bal", bal4, 64'd750);
        chk("lit_w750_tr", 64'(tr4), 64'd1);
        tarjeta_recibida = 1'b0; tick();
        chk("lit_tr_hold", 64'(tr4), 64'd1);
        tarjeta_recibida = 1'b1; tick();
        chk("lit_reopen2", bal4, 64'd750);
        tarjeta_recibida = 1'b0; tick();
        cuenta_id = 2'd1; tarjeta_recibida = 1'b1; tick();
        chk("lit_acct1", bal4, 64'd1000);
        tarjeta_recibida = 1'b0; tick();

        cuenta_id = 2'd0; tarjeta_recibida = 1'b1; tick();
        balance_stb = 1'b1;
        balance_actualizado = 64'd900; tick();
        balance_actualizado = 64'd800; cuenta_id = 2'd3; tick();
        balance_actualizado = 64'd700; cuenta_id = 2'd1; tick();
        chk("lit_b2b_ok", 64'(ok4), 64'd1);
        balance_stb = 1'b0; tick();
        chk("lit_b2b_tr", 64'(tr4), 64'd3);
        chk("lit_b2b_bal", bal4, 64'd700);
        tarjeta_recibida = 1'b0; tick();

        balance_actualizado = 64'd5; balance_stb = 1'b1; tick();
        chk("lit_idle_err", 64'(err4), 64'd1);
        chk("lit_idle_ok", 64'(ok4), 64'd0);
        balance_stb = 1'b0; tick();
        cuenta_id = 2'd3; tarjeta_recibida = 1'b1; tick();
        chk("lit_acct3", bal4, 64'd1000);
        chk("lit_rech_inv", 64'(inv3), 64'd1);
        chk("lit_rech_val", 64'(val3), 64'd0);
        balance_actualizado = 64'd9; balance_stb = 1'b1; tick();
        chk("lit_rech_err", 64'(err3), 64'd1);
        balance_stb = 1'b0; tick();
        tick();
        tarjeta_recibida = 1'b0; tick();
        chk("lit_rech_exit", 64'(inv3), 64'd0);

        cuenta_id = 2'd2; tarjeta_recibida = 1'b1; tick();
        tarjeta_recibida = 1'b0; balance_actualizado = 64'd55; balance_stb = 1'b1; tick();
        chk("lit_drop_ok", 64'(ok4), 64'd1);
        chk("lit_drop_val", 64'(val4), 64'd0);
        balance_stb = 1'b0; tarjeta_recibida = 1'b1; tick();
        chk("lit_drop_commit", bal4, 64'd55);
        tarjeta_recibida = 1'b0; tick();

        cuenta_id = 2'd0; tarjeta_recibida = 1'b1; tick();
        balance_stb = 1'b1;
        for (int i = 0; i < 260; i++) begin
            balance_actualizado = 64'(i);
            tick();
        end
        balance_stb = 1'b0; tick();
        chk("lit_sat", 64'(tr4), 64'd255);
        tarjeta_recibida = 1'b0; tick();

        cuenta_id = 2'd1; tarjeta_recibida = 1'b1; tick();
        balance_actualizado = 64'd400; balance_stb = 1'b1; tick();
        balance_stb = 1'b0; tick();
        chk("lit_w400", bal4, 64'd400);
        reset = 1'b0; balance_stb = 1'b1; balance_actualizado = 64'd123; tick();
        chk("lit_rst_bal", bal4, 64'd0);
        chk("lit_rst_val", 64'(val4), 64'd0);
        reset = 1'b1; balance_stb = 1'b0; tarjeta_recibida = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            cuenta_id = 2'(i); tarjeta_recibida = 1'b1; tick();
            chk("lit_post_rst", bal4, 64'd1000);
            tarjeta_recibida = 1'b0; tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
